// File: rtl/octree_lod_loader.sv
// Packs a stream of FP16 octree records (anchor then per-level deltas) four per SRAM word
// and writes them at the per-tree layout read by lod_compute.
module octree_lod_loader #(
  parameter int unsigned DIMENTION      = 3,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned DATA_BUS_WIDTH = 64,
  parameter int unsigned ADDR_BUS_WIDTH = 64,
  parameter int unsigned TREE_LEVEL     = 5,
  parameter int unsigned LOD_START_ADDR = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_start,
  input  logic [DATA_WIDTH-1:0]     tree_count,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_ready,
  input  logic                      mem_gnt,
  output logic                      mem_sram_CEN,
  output logic                      mem_sram_GWEN,
  output logic [ADDR_BUS_WIDTH-1:0] mem_sram_A,
  output logic [DATA_BUS_WIDTH-1:0] mem_sram_D,
  output logic                      busy,
  output logic                      load_done,
  output logic [DATA_WIDTH-1:0]     trees_loaded
);

  localparam int unsigned VALS_PER_TREE = DIMENTION + TREE_LEVEL;
  localparam int unsigned LANES         = DATA_BUS_WIDTH / DATA_WIDTH;
  localparam int unsigned LANE_W        = $clog2(LANES);
  localparam int unsigned ELEM_W        = $clog2(VALS_PER_TREE + 1);

  typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;

  state_e                    state_q, state_d;
  logic [LANE_W-1:0]         lane_q, lane_d;
  logic [ELEM_W-1:0]         elem_q, elem_d;
  logic                      tree_end_q, tree_end_d;
  logic [DATA_BUS_WIDTH-1:0] word_q, word_d;
  logic [ADDR_BUS_WIDTH-1:0] word_ptr_q, word_ptr_d;
  logic [DATA_WIDTH-1:0]     tree_count_q, tree_count_d;
  logic [DATA_WIDTH-1:0]     loaded_q, loaded_d;
  logic                      wr_en;
  int unsigned               lane_lsb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      lane_q       <= '0;
      elem_q       <= '0;
      tree_end_q   <= 1'b0;
      word_q       <= '0;
      word_ptr_q   <= '0;
      tree_count_q <= '0;
      loaded_q     <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      elem_q       <= elem_d;
      tree_end_q   <= tree_end_d;
      word_q       <= word_d;
      word_ptr_q   <= word_ptr_d;
      tree_count_q <= tree_count_d;
      loaded_q     <= loaded_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    elem_d       = elem_q;
    tree_end_d   = tree_end_q;
    word_d       = word_q;
    word_ptr_d   = word_ptr_q;
    tree_count_d = tree_count_q;
    loaded_d     = loaded_q;
    in_ready     = 1'b0;
    wr_en        = 1'b0;
    busy         = 1'b0;
    load_done    = 1'b0;
    // Lane 0 sits in the MSBs so the first element of a word lands on top.
    lane_lsb     = (LANES - 1 - 32'(lane_q)) * DATA_WIDTH;

    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          tree_count_d = tree_count;
          loaded_d     = '0;
          word_ptr_d   = '0;
          lane_d       = '0;
          elem_d       = '0;
          word_d       = '0;
          tree_end_d   = 1'b0;
          state_d      = (tree_count == '0) ? StDone : StFill;
        end
      end
      StFill: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          word_d[lane_lsb +: DATA_WIDTH] = in_data;
          if (elem_q == ELEM_W'(VALS_PER_TREE - 1)) begin
            // Tree boundary: flush a partial word so the next tree starts at lane 0.
            elem_d     = '0;
            lane_d     = '0;
            tree_end_d = 1'b1;
            state_d    = StWrite;
          end else if (lane_q == LANE_W'(LANES - 1)) begin
            elem_d     = elem_q + 1'b1;
            lane_d     = '0;
            tree_end_d = 1'b0;
            state_d    = StWrite;
          end else begin
            elem_d = elem_q + 1'b1;
            lane_d = lane_q + 1'b1;
          end
        end
      end
      StWrite: begin
        busy = 1'b1;
        if (mem_gnt) begin
          wr_en      = 1'b1;
          word_ptr_d = word_ptr_q + 1'b1;
          word_d     = '0;
          state_d    = StFill;
          if (tree_end_q) begin
            loaded_d = loaded_q + 1'b1;
            if (loaded_q + 1'b1 == tree_count_q) state_d = StDone;
          end
        end
      end
      StDone: begin
        load_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_sram_CEN  = ~wr_en;
  assign mem_sram_GWEN = ~wr_en;
  assign mem_sram_A    = wr_en ? (ADDR_BUS_WIDTH'(LOD_START_ADDR) + word_ptr_q) : '0;
  assign mem_sram_D    = wr_en ? word_q : '0;
  assign trees_loaded  = loaded_q;

endmodule
